rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Eight-requester round-robin arbiter for a single shared resource. It extends the 8-to-3 priority encoder into a sequential grant controller:
- rotating priority replaces fixed priority;
- grants are registered and held until the owner releases;
- an optional hold-time limit preempts an owner when others are waiting.

It sits between up to eight bus or port clients and one shared datapath. Its one-hot grant and 3-bit index drive the resource's select mux.

## Interface
- HOLD_MAX, default 16: maximum consecutive cycles one owner keeps the grant while others request. Range 0..255. 0 disables preemption.
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  arbitration enable; 0 blocks new grants and handovers
- req  in  8  request vector; req[i] held high by client i while it wants or uses the resource
- gnt  out  8  one-hot grant, registered
- gnt_id  out  3  binary index of granted client, registered; 0 when no grant
- gnt_valid  out  1  registered; 1 iff gnt != 0
- idle  out  1  combinational: en & ~|req & ~gnt_valid

## Operation
- States: IDLE (no owner), GRANT (owner = gnt_id). One 3-bit rotation pointer ptr. One 8-bit hold counter hcnt.
- Priority search:
  - Candidates are searched in order ptr, ptr+1, …, ptr+7, mod 8 wrap.
  - The first candidate with its request bit set wins.
  - The search is a rotate, fixed-priority encode, then un-rotate.
- IDLE, en=1, req!=0: register winner into gnt/gnt_id, set gnt_valid, hcnt <= 0, go to GRANT.
- IDLE with en=0 or req=0: stay, outputs 0.
- GRANT, release (req[owner]=0):
  - ptr <= owner+1 (mod 8).
  - If en=1 and another request exists, hand over directly to the winner of a search from owner+1, excluding the owner. hcnt <= 0.
  - Otherwise clear gnt/gnt_id/gnt_valid and go to IDLE.
- GRANT, owner still requesting:
  - hcnt increments, saturating at 255.
  - Preempt when HOLD_MAX!=0, hcnt == HOLD_MAX-1, en=1, and any other req bit is set.
  - On preemption: ptr <= owner+1, hand over as on release, hcnt <= 0.
  - Without other requesters, the owner keeps the grant indefinitely and hcnt saturates.
- en=0 in GRANT: the current owner keeps the grant, with no preemption. On release, go to IDLE.
- gnt is always one-hot or zero. A grant is never given to a client whose req is 0 in the deciding cycle.

## Timing
- Reset (rst=1 at edge): gnt=0, gnt_id=0, gnt_valid=0, ptr=0, hcnt=0, state=IDLE. Reset overrides all other inputs, including mid-grant.
- Request-to-grant latency: req sampled at edge N gives gnt at edge N+1 (1 cycle).
- Release-to-handover: req[owner] low at edge N gives the new gnt at edge N+1. There is no idle bubble and no overlap; gnt changes atomically.
- Preemption: an owner granted at edge G holds through edge G+HOLD_MAX-1. The new gnt appears at edge G+HOLD_MAX.
- idle follows inputs within the same cycle; all other outputs are registered.
- Simultaneous release and preemption condition: treat as release; ptr update is identical.

## Test plan
- Basic grant and wrap:
  - After reset, en=1, req=8'b1000_0001 → next cycle gnt=8'b0000_0001, gnt_id=0, gnt_valid=1.
  - Drop req[0] → next cycle gnt=8'b1000_0000, gnt_id=7.
  - Drop req[7] → gnt=0, idle=1.
- Rotation fairness: HOLD_MAX=4, req=8'hFF held → gnt_id sequence 0,1,…,7,0, each held exactly 4 cycles, no gaps.
- No contention: HOLD_MAX=4, req=8'b0000_0100 for 20 cycles → gnt_id=2 held for all cycles after the first. hcnt saturation causes no preemption.
- Pointer priority: owner 5 releases while req=8'b0001_1001 → next gnt_id=0, since the search order is 6,7,0. Then release 0 → gnt_id=3.
- Enable gating:
  - en=0, req=8'h10 → gnt stays 0, idle=0.
  - en dropped mid-grant with others requesting → owner holds past HOLD_MAX. On release, gnt=0 even with others pending.
  - Raising en → grant the next cycle.
- Reset mid-grant: rst=1 while gnt_id=6 → next edge all outputs 0. With req=8'hFF after rst falls → gnt_id=0 (ptr back to 0).

Source files
------------

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between up to eight clients and the round-robin arbiter.
// The master side drives enable and requests; the slave side returns the grant.
interface rr_arbiter8_if;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       idle;

    modport master (output en, req, input gnt, gnt_id, gnt_valid, idle);
    modport slave  (input en, req, output gnt, gnt_id, gnt_valid, idle);
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with registered one-hot grant and an
// optional hold-time limit that preempts an owner while others are waiting.
module rr_arbiter8 #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    rr_arbiter8_if.slave  bus
);
    typedef enum logic [0:0] {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

    localparam bit         HOLD_EN   = (HOLD_MAX != 0);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     r_state, w_state_nxt;
    logic [2:0] r_ptr, w_ptr_nxt;
    logic [7:0] r_hcnt, w_hcnt_nxt;
    logic [7:0] r_gnt, w_gnt_nxt;
    logic [2:0] r_gnt_id, w_gnt_id_nxt;
    logic       r_gnt_valid;

    logic [3:0] w_idle_pick;
    logic [3:0] w_hand_pick;
    logic       w_own_req;
    logic       w_others;
    logic       w_preempt;

    // Rotate so 'start' sits at bit 0, take the lowest set bit, rotate back.
    // Returns {found, index}.
    function automatic logic [3:0] rr_pick(input logic [7:0] reqv, input logic [2:0] start);
        logic [15:0] dbl;
        logic [7:0]  rot;
        logic [2:0]  k;
        logic        found;
        dbl   = {reqv, reqv};
        rot   = dbl[start +: 8];
        k     = 3'd0;
        found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            k     = rot[i] ? 3'(i) : k;
            found = found | rot[i];
        end
        return {found, 3'(start + k)};
    endfunction

    assign w_own_req   = |(bus.req & r_gnt);
    assign w_others    = |(bus.req & ~r_gnt);
    assign w_idle_pick = rr_pick(bus.req, r_ptr);
    assign w_hand_pick = rr_pick(bus.req & ~r_gnt, r_gnt_id + 3'd1);
    assign w_preempt   = HOLD_EN && (r_hcnt == HOLD_LAST) && bus.en && w_others;

    // Next-state, pointer, hold counter and grant decision.
    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_hcnt_nxt   = r_hcnt;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        case (r_state)
            S_IDLE: begin
                if (bus.en && w_idle_pick[3]) begin
                    w_gnt_nxt    = 8'd1 << w_idle_pick[2:0];
                    w_gnt_id_nxt = w_idle_pick[2:0];
                    w_hcnt_nxt   = 8'd0;
                    w_state_nxt  = S_GRANT;
                end else begin
                    w_gnt_nxt    = 8'd0;
                    w_gnt_id_nxt = 3'd0;
                end
            end
            S_GRANT: begin
                if (!w_own_req) begin
                    // Release wins over a coincident preemption; pointer update is the same.
                    w_ptr_nxt  = r_gnt_id + 3'd1;
                    w_hcnt_nxt = 8'd0;
                    if (bus.en && w_hand_pick[3]) begin
                        w_gnt_nxt    = 8'd1 << w_hand_pick[2:0];
                        w_gnt_id_nxt = w_hand_pick[2:0];
                    end else begin
                        w_gnt_nxt    = 8'd0;
                        w_gnt_id_nxt = 3'd0;
                        w_state_nxt  = S_IDLE;
                    end
                end else if (w_preempt) begin
                    w_ptr_nxt    = r_gnt_id + 3'd1;
                    w_hcnt_nxt   = 8'd0;
                    w_gnt_nxt    = 8'd1 << w_hand_pick[2:0];
                    w_gnt_id_nxt = w_hand_pick[2:0];
                end else begin
                    w_hcnt_nxt = (r_hcnt == 8'hFF) ? r_hcnt : r_hcnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_gnt_nxt    = 8'd0;
                w_gnt_id_nxt = 3'd0;
                w_hcnt_nxt   = 8'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= 3'd0;
            r_hcnt      <= 8'd0;
            r_gnt       <= 8'd0;
            r_gnt_id    <= 3'd0;
            r_gnt_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hcnt      <= w_hcnt_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_gnt_valid <= |w_gnt_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_id    = r_gnt_id;
    assign bus.gnt_valid = r_gnt_valid;
    assign bus.idle      = bus.en & ~|bus.req & ~r_gnt_valid;
endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8 (HOLD_MAX=4): expected grants are queued as
// each cycle's inputs are driven and compared just after the following edge.
module tb_rr_arbiter8;
    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] id;
        logic       v;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    rr_arbiter8_if bus ();

    rr_arbiter8 #(.HOLD_MAX(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int id, input bit v);
        exp_t e;
        e.gnt = v ? (8'd1 << id) : 8'd0;
        e.id  = v ? 3'(id) : 3'd0;
        e.v   = v;
        return e;
    endfunction

    task automatic pop_check(input string tag);
        exp_t e;
        logic exp_idle;
        if (sb.size() == 0) begin
            check_eq({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            exp_idle = bus.en & (bus.req == 8'd0) & ~e.v;
            check_eq({tag, ".gnt"},   32'(bus.gnt),       32'(e.gnt));
            check_eq({tag, ".id"},    32'(bus.gnt_id),    32'(e.id));
            check_eq({tag, ".valid"}, 32'(bus.gnt_valid), 32'(e.v));
            check_eq({tag, ".idle"},  32'(bus.idle),      32'(exp_idle));
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge state, then check it.
    task automatic cyc(input string tag, input logic en, input logic [7:0] req,
                       input int id, input bit v);
        bus.en  = en;
        bus.req = req;
        sb.push_back(mk(id, v));
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    task automatic rst_cyc(input string tag, input logic en, input logic [7:0] req);
        rst     = 1'b1;
        bus.en  = en;
        bus.req = req;
        sb.push_back(mk(0, 1'b0));
        @(posedge clk);
        #1;
        pop_check(tag);
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        bus.en  = 1'b0;
        bus.req = 8'd0;
        @(posedge clk);
        #1;
        rst_cyc("reset", 1'b0, 8'd0);

        // Basic grant, wrap to 7, then idle.
        cyc("basic0", 1'b1, 8'b1000_0001, 0, 1'b1);
        cyc("basic7", 1'b1, 8'b1000_0000, 7, 1'b1);
        cyc("basic_idle", 1'b1, 8'b0000_0000, 0, 1'b0);

        // Full contention: each client holds exactly four cycles, in order.
        for (int c = 0; c < 36; c++)
            cyc($sformatf("rot%0d", c), 1'b1, 8'hFF, (c / 4) % 8, 1'b1);
        cyc("rot_rel", 1'b1, 8'h00, 0, 1'b0);

        // Lone requester is never preempted.
        for (int c = 0; c < 20; c++)
            cyc($sformatf("solo%0d", c), 1'b1, 8'b0000_0100, 2, 1'b1);
        cyc("solo_rel", 1'b1, 8'h00, 0, 1'b0);

        // Pointer priority: after owner 5 the order is 6,7,0,...
        cyc("ptr5", 1'b1, 8'b0010_0000, 5, 1'b1);
        cyc("ptr0", 1'b1, 8'b0001_1001, 0, 1'b1);
        cyc("ptr3", 1'b1, 8'b0001_1000, 3, 1'b1);
        cyc("ptr_rel", 1'b1, 8'h00, 0, 1'b0);

        // Enable gating.
        cyc("en_off0", 1'b0, 8'h10, 0, 1'b0);
        cyc("en_off1", 1'b0, 8'h10, 0, 1'b0);
        cyc("en_on", 1'b1, 8'h10, 4, 1'b1);
        for (int c = 0; c < 8; c++)
            cyc($sformatf("en_hold%0d", c), 1'b0, 8'h11, 4, 1'b1);
        cyc("en_rel", 1'b0, 8'h01, 0, 1'b0);
        cyc("en_rel2", 1'b0, 8'h01, 0, 1'b0);
        cyc("en_regrant", 1'b1, 8'h01, 0, 1'b1);

        // Reset mid-grant returns the pointer to 0.
        cyc("pre6", 1'b1, 8'h40, 6, 1'b1);
        cyc("hold6", 1'b1, 8'h40, 6, 1'b1);
        rst_cyc("rst_mid", 1'b1, 8'hFF);
        cyc("post_rst0", 1'b1, 8'hFF, 0, 1'b1);
        cyc("post_rst1", 1'b1, 8'hFF, 0, 1'b1);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
